alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Repeated-operation sequencer: drives an external combinational ALU cmd_rpt+1 times and returns the final result.
// Optional macro ALU_SEQ_PIPE_EN lets a new command be accepted on the same edge as the response handshake.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_x,
    input  logic [15:0] cmd_y,
    input  logic [3:0]  cmd_rpt,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_z,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_z,
    output logic        rsp_zero
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rsp_z_q, rsp_z_d;
    logic        load;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        rsp_z_d   = rsp_z_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // cnt counts remaining feedback passes; the last pass goes to rsp_z instead.
                if (cnt_q != 4'd0) begin
                    if (op_q[3]) begin
                        y_d = alu_z;
                    end else begin
                        x_d = alu_z;
                    end
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_z_d = alu_z;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
`ifdef ALU_SEQ_PIPE_EN
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        load    = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            op_d  = cmd_op;
            x_d   = cmd_x;
            y_d   = cmd_y;
            cnt_d = cmd_rpt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 4'd0;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            cnt_q   <= 4'd0;
            rsp_z_q <= 16'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            rsp_z_q <= rsp_z_d;
        end
    end

    // ALU operands come straight from registers so cmd_* never reaches the ALU combinationally.
    assign alu_x    = x_q;
    assign alu_y    = y_q;
    assign alu_op   = op_q;
    assign rsp_z    = rsp_z_q;
    assign rsp_zero = (rsp_z_q == 16'h0000);

endmodule
